mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of EX. It registers the EX-to-MEM bus and takes the synchronous data-SRAM read data returned one cycle after EX issued the address. It aligns and extends that data for lb/lbu/lh/lhu/lw, then selects the register-file write value. It drives the MEM-to-WB bus and the MEM-to-ID forwarding bus, and holds load data stable across MEM stalls.

## Interface
- No parameters; widths come from the shared defines: `EX_TO_MEM_WD`=82, `MEM_TO_WB_WD`=70, `MEM_TO_ID_WD`=38, `StallBus`=6.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  `StallBus`  pipeline stall vector; bit 3 = EX, bit 4 = MEM, `Stop`=1.
- ex_to_mem_bus  in  82  {ld_type[81:76], pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- data_sram_rdata  in  32  SRAM read data, valid in the first cycle the load occupies MEM.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id_bus  out  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}, for forwarding.
- mem_addr_err  out  1  misaligned load/store flag (see Configuration).

## Operation
- Input register `bus_r`:
  - rst → 0.
  - Else if stall[3]=Stop and stall[4]=NoStop → 0 (bubble).
  - Else if stall[3]=NoStop → capture ex_to_mem_bus.
  - Else hold.
- `fresh` flag:
  - Set to 1 whenever `bus_r` captures or bubbles.
  - Cleared on the following edge.
  - rst → 0.
- Load-data hold buffer (`rdata_h`, `hold_v`):
  - Capture data_sram_rdata into `rdata_h` and set `hold_v`=1 when all hold: fresh=1, stall[4]=Stop, ram_en=1, ram_wen=0.
  - Clear `hold_v` when stall[4]=NoStop.
  - rst clears both.
- Effective data: `rd` = hold_v ? rdata_h : data_sram_rdata.
- Alignment uses offset `off` = ex_result[1:0], little-endian byte lanes (lane k = rd[8k+7:8k]):
  - lb (100000): sign-extend lane `off`.
  - lbu (100100): zero-extend lane `off`.
  - lh (100001): sign-extend half `off[1]`.
  - lhu (100101): zero-extend half `off[1]`.
  - lw (100011): rd unchanged.
  - Any other ld_type: 0.
- rf_wdata = sel_rf_res ? load_data : ex_result.
- mem_to_wb_bus and mem_to_id_bus are combinational from `bus_r`, the hold buffer and data_sram_rdata; the ID bus equals the low 38 bits of the WB bus.
- Stores (ram_wen≠0) pass ex_result through; sel_rf_res=0 for them.

## Timing
- Latency: one register stage; an instruction leaves EX at edge N and its results are visible on both output buses during cycle N+1.
- Reset: `bus_r`=0, fresh=0, hold_v=0, rdata_h=0. Every output bus and mem_addr_err is 0 in the cycle after rst.
- SRAM read data is assumed valid only in the fresh cycle; stalled load output must stay constant for the whole stall.
- Simultaneous bubble insertion and hold_v=1: hold_v clears because stall[4]=NoStop, so the bubble never uses stale data.
- A stall[4] spanning many cycles leaves `rdata_h` unchanged.
- rst asserted mid-stall: reset wins over stall and hold.

## Configuration
- `MEM_ADDR_CHECK_EN` defined:
  - mem_addr_err=1 for a misaligned access: a half-word access with off[0]=1, or a word access with off≠0.
  - Half-word access = lh, lhu, or ram_wen 0011; word access = lw or ram_wen 1111.
  - On a flagged access, rf_we is forced to 0 on both output buses.
- Macro undefined: mem_addr_err tied to 0 and no rf_we masking.

## Structure
- Shared package/defines:
  - Bus widths and stall constants (`Stop`, `NoStop`).
  - Load opcode constants: `OP_LB`, `OP_LBU`, `OP_LH`, `OP_LHU`, `OP_LW`.
- One sub-module `load_align`, purely combinational: (ld_type, off, rd) → load_data.
- Registers, hold buffer and muxing stay in mem_stage.

## Test plan
- Reset: rst=1 for 2 cycles → mem_to_wb_bus=0, mem_to_id_bus=0, mem_addr_err=0.
- lb, off=3, rdata=0x80AA55CC, sel_rf_res=1, waddr=8 → rf_wdata=0xFFFFFF80, rf_we=1, waddr=8 the next cycle. lbu with the same inputs → 0x00000080.
- lh, off=2, rdata=0x9234_0001 → 0xFFFF9234. lhu → 0x00009234. lw → 0x92340001.
- Load with stall[4]=Stop for 3 cycles while rdata changes to 0xDEADBEEF after the first cycle → rf_wdata holds the first-cycle value throughout the stall and in the release cycle.
- stall[3]=Stop, stall[4]=NoStop with a valid EX bus → next cycle all outputs 0. Non-load addu with ex_result=0x1234, sel_rf_res=0 → rf_wdata=0x1234.
- With `MEM_ADDR_CHECK_EN`: lw at off=2 → mem_addr_err=1 and rf_we=0. Without the macro: mem_addr_err=0 and rf_we=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared widths, stall encoding, load opcodes and bus layouts for the MEM
//   stage of the five-stage MIPS pipeline.
//   Also provides access-size helpers used by the optional misalignment
//   checker (enabled by defining MEM_ADDR_CHECK_EN).
package mem_stage_pkg;

    // Bus widths shared with the neighbouring pipeline stages.
    localparam int EX_TO_MEM_WD = 82;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;
    localparam int StallBus     = 6;

    // Stall vector encoding and the bit positions this stage looks at.
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam int   STALL_EX  = 3;
    localparam int   STALL_MEM = 4;

    // Load type codes carried in ld_type (the MIPS primary opcodes).
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    // Store byte-enable patterns that identify half-word and word stores.
    localparam logic [3:0] WEN_HALF = 4'b0011;
    localparam logic [3:0] WEN_WORD = 4'b1111;

    // EX-to-MEM bus, MSB first exactly as EX packs it.
    typedef struct packed {
        logic [5:0]  ld_type;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    // MEM-to-WB bus; its low MEM_TO_ID_WD bits form the forwarding bus.
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    // True for lh/lhu or a half-word store.
    function automatic logic is_half_access(input logic [5:0] ld_type,
                                            input logic [3:0] ram_wen);
        return (ld_type == OP_LH) || (ld_type == OP_LHU) || (ram_wen == WEN_HALF);
    endfunction

    // True for lw or a full-word store.
    function automatic logic is_word_access(input logic [5:0] ld_type,
                                            input logic [3:0] ram_wen);
        return (ld_type == OP_LW) || (ram_wen == WEN_WORD);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align
//   Purely combinational load-data alignment. Picks the addressed byte or
//   half-word out of a little-endian 32-bit SRAM word and sign/zero extends
//   it according to the load type.
// Ports:
//   ld_type   in  6   load opcode (OP_LB/LBU/LH/LHU/LW, anything else -> 0)
//   off       in  2   byte offset within the word (address bits [1:0])
//   rd        in  32  raw read data word
//   load_data out 32  aligned, extended result
module load_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  ld_type,
    input  logic [1:0]  off,
    input  logic [31:0] rd,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // Lane k sits at rd[8k+7:8k]; half-words are chosen by off[1] only,
        // so a misaligned half still returns the enclosing aligned half.
        byte_v = rd[{off, 3'b000} +: 8];
        half_v = off[1] ? rd[31:16] : rd[15:0];

        case (ld_type)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'h0, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'h0, half_v};
            OP_LW:   load_data = rd;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage of the five-stage MIPS pipeline. Registers the
//   EX-to-MEM bus, aligns the synchronous data-SRAM read data for loads,
//   selects the register-file write value and drives the WB and ID
//   (forwarding) buses. A small hold buffer keeps load data stable while
//   MEM is stalled, since the SRAM only presents valid data in the first
//   cycle a load occupies MEM.
//
//   Optional feature: define MEM_ADDR_CHECK_EN to flag misaligned half-word
//   and word accesses on mem_addr_err and suppress their register write.
//   Without it mem_addr_err is tied low.
//
// Ports:
//   clk              in  1   clock, rising edge
//   rst              in  1   synchronous active-high reset
//   stall            in  6   stall vector (bit 3 = EX, bit 4 = MEM)
//   ex_to_mem_bus    in  82  registered EX results (see ex_to_mem_t)
//   data_sram_rdata  in  32  SRAM read data, valid in the load's first MEM cycle
//   mem_to_wb_bus    out 70  {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_id_bus    out 38  {rf_we, rf_waddr, rf_wdata} for forwarding
//   mem_addr_err     out 1   misaligned access flag
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    mem_addr_err
);

    ex_to_mem_t  bus_q,     bus_d;
    logic        fresh_q,   fresh_d;
    logic [31:0] rdata_h_q, rdata_h_d;
    logic        hold_v_q,  hold_v_d;

    logic        ex_stop;
    logic        mem_stop;
    logic [31:0] rd;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        addr_err;
    mem_to_wb_t  wb_out;

    assign ex_stop  = (stall[STALL_EX]  == Stop);
    assign mem_stop = (stall[STALL_MEM] == Stop);

    // Input register. When EX stalls but MEM moves on, a bubble is pushed
    // so the instruction in MEM is not retired twice. fresh marks the one
    // cycle after a capture or bubble, the only cycle the SRAM data is live.
    always_comb begin
        bus_d   = bus_q;
        fresh_d = 1'b0;
        if (ex_stop && !mem_stop) begin
            bus_d   = '0;
            fresh_d = 1'b1;
        end else if (!ex_stop) begin
            bus_d   = ex_to_mem_t'(ex_to_mem_bus);
            fresh_d = 1'b1;
        end
    end

    // Hold buffer: a stalled load snapshots the SRAM word on its first
    // cycle so the output stays constant even if the SRAM data moves on.
    // Clearing whenever MEM advances guarantees a bubble or the next
    // instruction never sees the stale snapshot.
    always_comb begin
        hold_v_d  = hold_v_q;
        rdata_h_d = rdata_h_q;
        if (!mem_stop) begin
            hold_v_d = 1'b0;
        end else if (fresh_q && bus_q.ram_en && (bus_q.ram_wen == 4'b0000)) begin
            hold_v_d  = 1'b1;
            rdata_h_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q     <= '0;
            fresh_q   <= 1'b0;
            rdata_h_q <= 32'h0;
            hold_v_q  <= 1'b0;
        end else begin
            bus_q     <= bus_d;
            fresh_q   <= fresh_d;
            rdata_h_q <= rdata_h_d;
            hold_v_q  <= hold_v_d;
        end
    end

    assign rd = hold_v_q ? rdata_h_q : data_sram_rdata;

    load_align u_load_align (
        .ld_type   (bus_q.ld_type),
        .off       (bus_q.ex_result[1:0]),
        .rd        (rd),
        .load_data (load_data)
    );

    // Stores and ALU ops carry sel_rf_res=0 and pass ex_result through.
    assign rf_wdata = bus_q.sel_rf_res ? load_data : bus_q.ex_result;

`ifdef MEM_ADDR_CHECK_EN
    logic half_acc;
    logic word_acc;

    assign half_acc = is_half_access(bus_q.ld_type, bus_q.ram_wen);
    assign word_acc = is_word_access(bus_q.ld_type, bus_q.ram_wen);
    assign addr_err = (half_acc && bus_q.ex_result[0])
                   || (word_acc && (bus_q.ex_result[1:0] != 2'b00));
`else
    assign addr_err = 1'b0;
`endif

    // A flagged access must not update the register file, so rf_we is
    // masked on both buses (the ID bus is a slice of the WB bus).
    always_comb begin
        wb_out          = '0;
        wb_out.pc       = bus_q.pc;
        wb_out.rf_we    = bus_q.rf_we && !addr_err;
        wb_out.rf_waddr = bus_q.rf_waddr;
        wb_out.rf_wdata = rf_wdata;
    end

    assign mem_to_wb_bus = wb_out;
    assign mem_to_id_bus = wb_out[MEM_TO_ID_WD-1:0];
    assign mem_addr_err  = addr_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven load/ALU/store vectors
// plus hand-written stall, bubble and reset sequences, all checked through
// a scoreboard queue of expected bus values.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [81:0] ex_bus;
    logic [31:0] rdata;
    logic [69:0] wb;
    logic [37:0] id;
    logic        err;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb),
        .mem_to_id_bus   (id),
        .mem_addr_err    (err)
    );

    always #5 clk = ~clk;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001,
                           LHU = 6'b100101, LW = 6'b100011;
    localparam logic [5:0] ST_MEM  = 6'b011111;   // MEM and upstream stalled
    localparam logic [5:0] ST_BUBL = 6'b001111;   // EX stalled, MEM moves

    typedef struct {
        logic [5:0]  ld;
        logic        ram_en;
        logic [3:0]  wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] exr;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic        misalign;
    } vec_t;

    typedef struct {
        logic [69:0] wb;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [81:0] mk_bus(input vec_t v, input logic [31:0] pc);
        return {v.ld, pc, v.ram_en, v.wen, v.sel, v.we, v.waddr, v.exr};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input logic we,
                                    input logic [4:0] waddr, input logic [31:0] wdata,
                                    input logic misalign);
        exp_t e;
        e.err = CHK & misalign;
        e.wb  = {pc, we & ~e.err, waddr, wdata};
        return e;
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, "_wb"}, wb, e.wb);
            check({name, "_id"}, {32'h0, id}, {32'h0, e.wb[37:0]});
            check({name, "_err"}, {69'h0, err}, {69'h0, e.err});
        end
    endtask

    // One instruction: present on the EX bus, capture, supply SRAM data in
    // the fresh cycle and compare mid-cycle.
    task automatic apply(input vec_t v, input logic [31:0] pc, input string name);
        @(posedge clk); #1;
        ex_bus = mk_bus(v, pc);
        stall  = 6'b0;
        @(posedge clk); #1;
        ex_bus = '0;
        rdata  = v.rdata;
        sb.push_back(mk_exp(pc, v.we, v.waddr, v.exp_wdata, v.misalign));
        @(negedge clk);
        sb_check(name);
    endtask

    initial begin
        vec_t lw_v;
        //         ld     en  wen    sel we waddr exr           rdata         expected      mis
        vecs[0]  = '{LB,   1, 4'h0, 1, 1, 5'd8, 32'h1000_0003, 32'h80AA55CC, 32'hFFFFFF80, 0};
        vecs[1]  = '{LBU,  1, 4'h0, 1, 1, 5'd8, 32'h1000_0003, 32'h80AA55CC, 32'h00000080, 0};
        vecs[2]  = '{LB,   1, 4'h0, 1, 1, 5'd4, 32'h1000_0000, 32'h80AA55CC, 32'hFFFFFFCC, 0};
        vecs[3]  = '{LBU,  1, 4'h0, 1, 1, 5'd5, 32'h1000_0001, 32'h80AA55CC, 32'h00000055, 0};
        vecs[4]  = '{LH,   1, 4'h0, 1, 1, 5'd6, 32'h1000_0002, 32'h92340001, 32'hFFFF9234, 0};
        vecs[5]  = '{LHU,  1, 4'h0, 1, 1, 5'd7, 32'h1000_0002, 32'h92340001, 32'h00009234, 0};
        vecs[6]  = '{LW,   1, 4'h0, 1, 1, 5'd9, 32'h1000_0000, 32'h92340001, 32'h92340001, 0};
        vecs[7]  = '{LH,   1, 4'h0, 1, 1, 5'd10, 32'h1000_0000, 32'h92340001, 32'h00000001, 0};
        vecs[8]  = '{6'h0, 0, 4'h0, 0, 1, 5'd3, 32'h0000_1234, 32'hCAFEF00D, 32'h00001234, 0};
        vecs[9]  = '{6'h0, 1, 4'hF, 0, 0, 5'd0, 32'h2000_0004, 32'h55555555, 32'h20000004, 0};
        vecs[10] = '{LW,   1, 4'h0, 1, 1, 5'd11, 32'h1000_0002, 32'h11223344, 32'h11223344, 1};
        vecs[11] = '{LH,   1, 4'h0, 1, 1, 5'd12, 32'h1000_0001, 32'h92340001, 32'h00000001, 1};
        vecs[12] = '{6'h3F, 1, 4'h0, 1, 1, 5'd13, 32'h1000_0000, 32'h92340001, 32'h00000000, 0};
        vecs[13] = '{6'h0, 1, 4'h3, 0, 0, 5'd0, 32'h2000_0001, 32'h0, 32'h20000001, 1};
        vecs[14] = '{LHU,  1, 4'h0, 1, 1, 5'd14, 32'h1000_0003, 32'h80017FFF, 32'h00008001, 1};
        vecs[15] = '{LB,   1, 4'h0, 1, 1, 5'd15, 32'h1000_0002, 32'h80AA55CC, 32'hFFFFFFAA, 0};

        // Reset with a live EX bus and nonzero SRAM data: outputs must be 0.
        rst    = 1'b1;
        stall  = 6'b0;
        rdata  = 32'hFFFF_FFFF;
        ex_bus = mk_bus(vecs[0], 32'hBFC0_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        sb.push_back(mk_exp(32'h0, 1'b0, 5'd0, 32'h0, 1'b0));
        @(negedge clk);
        sb_check("reset");
        rst    = 1'b0;
        ex_bus = '0;
        @(posedge clk); #1;
        sb.push_back(mk_exp(32'h0, 1'b0, 5'd0, 32'h0, 1'b0));
        @(negedge clk);
        sb_check("post_reset");

        for (int i = 0; i < 16; i++)
            apply(vecs[i], 32'hBFC0_0000 + 32'(i * 4), $sformatf("vec%0d", i));

        // Load stalled in MEM for 3 cycles; SRAM data changes after the first.
        lw_v = '{LW, 1, 4'h0, 1, 1, 5'd9, 32'h1000_0010, 32'h11112222, 32'h11112222, 0};
        @(posedge clk); #1;
        ex_bus = mk_bus(lw_v, 32'hBFC0_1000);
        stall  = 6'b0;
        @(posedge clk); #1;
        ex_bus = '0;
        rdata  = 32'h11112222;
        stall  = ST_MEM;
        for (int c = 0; c < 3; c++) begin
            sb.push_back(mk_exp(32'hBFC0_1000, 1'b1, 5'd9, 32'h11112222, 1'b0));
            @(negedge clk);
            sb_check($sformatf("stall_c%0d", c));
            @(posedge clk); #1;
            rdata = 32'hDEAD_BEEF;
            if (c == 2) stall = ST_BUBL;   // release cycle also inserts a bubble
        end
        sb.push_back(mk_exp(32'hBFC0_1000, 1'b1, 5'd9, 32'h11112222, 1'b0));
        @(negedge clk);
        sb_check("stall_release");
        @(posedge clk); #1;
        stall = 6'b0;
        sb.push_back(mk_exp(32'h0, 1'b0, 5'd0, 32'h0, 1'b0));
        @(negedge clk);
        sb_check("bubble_after_hold");
        // Next load must use live SRAM data, not the old snapshot.
        apply(vecs[6], 32'hBFC0_1010, "post_hold_load");

        // Bubble: EX stalled, MEM free, valid instruction waiting on the EX bus.
        @(posedge clk); #1;
        ex_bus = mk_bus(vecs[8], 32'hBFC0_2000);
        stall  = 6'b0;
        @(posedge clk); #1;
        ex_bus = mk_bus(vecs[6], 32'hBFC0_2004);
        rdata  = 32'h0BAD_0BAD;
        stall  = ST_BUBL;
        sb.push_back(mk_exp(32'hBFC0_2000, 1'b1, 5'd3, 32'h00001234, 1'b0));
        @(negedge clk);
        sb_check("addu_pre_bubble");
        @(posedge clk); #1;
        stall  = 6'b0;
        ex_bus = '0;
        sb.push_back(mk_exp(32'h0, 1'b0, 5'd0, 32'h0, 1'b0));
        @(negedge clk);
        sb_check("bubble");

        // Reset asserted while a load is held in a MEM stall.
        @(posedge clk); #1;
        ex_bus = mk_bus(lw_v, 32'hBFC0_3000);
        @(posedge clk); #1;
        ex_bus = '0;
        rdata  = 32'hAAAA_5555;
        stall  = ST_MEM;
        @(posedge clk); #1;
        rst   = 1'b1;
        rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        sb.push_back(mk_exp(32'h0, 1'b0, 5'd0, 32'h0, 1'b0));
        @(negedge clk);
        sb_check("reset_mid_stall");
        rst   = 1'b0;
        stall = 6'b0;
        apply(vecs[5], 32'hBFC0_3010, "post_reset_load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
